control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multi-cycle control unit for the RV32I core. It sequences the shared datapath (PC, instruction register, register file, immediate generator, ALU, unified memory port) through fetch, decode, execute, memory and write-back. It issues every datapath select and write-enable, runs a request/ready handshake on the single memory port, and counts retired instructions. It halts on an unsupported opcode.

## Interface
- No parameters. Opcode set and encodings are fixed.
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instruccion  in  32  IR contents; valid from DECODE onward; opcode = [6:0], funct3 = [14:12]
- zero  in  1  ALU result == 0; sampled only in EXEC of a branch
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write (store), 0 = read
- mem_addr_sel  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC
- pc_src  out  1  0 = ALU output (PC+4), 1 = target register
- target_write  out  1  latch ALU output into target register
- alu_a_sel  out  2  00 rs1, 01 PC, 10 old PC (PC of current instr)
- alu_b_sel  out  2  00 rs2, 01 Imm, 10 constant 4
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 ALU result, 01 memory data, 10 old PC+4, 11 Imm
- illegal  out  1  core halted on unsupported instruction
- instret  out  32  retired-instruction count

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. The state register and instret are the only flops. All outputs decode combinationally from state, opcode and funct3, and are 0 unless listed.
- FETCH: mem_req=1, mem_addr_sel=0, alu_a_sel=01, alu_b_sel=10, alu_op=00.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_a_sel=10, alu_b_sel=01, alu_op=00, target_write=1. Dispatch on opcode:
  - 0110111 LUI: go to WB.
  - 0110011 R-type, 0010011 OP-IMM, 0000011 LOAD, 0100011 STORE, 1101111 JAL: go to EXEC.
  - 1100011 BRANCH with funct3 000 or 001: go to EXEC.
  - Anything else: go to HALT.
- EXEC, by opcode:
  - R-type: alu_a_sel=00, alu_b_sel=00, alu_op=10, then WB.
  - OP-IMM: as R-type but alu_b_sel=01, then WB.
  - LOAD/STORE: alu_a_sel=00, alu_b_sel=01, alu_op=00, then MEM.
  - BRANCH: alu_a_sel=00, alu_b_sel=00, alu_op=01. Taken when (funct3=000 and zero) or (funct3=001 and !zero); if taken, pc_write=1, pc_src=1. Instruction retires, then FETCH.
  - JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=10. Retires, then FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - When mem_ready=1: a STORE retires and goes to FETCH; a LOAD goes to WB.
  - Otherwise stay in MEM.
- WB: reg_write=1; wb_sel=01 for LOAD, 11 for LUI, 00 otherwise. Retires, then FETCH.
- HALT: illegal=1, all enables 0. Leaves only on rst.
- instret: +1 on every retiring edge. Wraps 0xFFFFFFFF -> 0. Not incremented for an instruction that leads to HALT.

## Timing
- Reset: on a rising edge with rst=1, state becomes FETCH and instret becomes 0.
  - While rst=1, all outputs are forced to 0, including mem_req.
  - Reset mid-handshake drops the request. The first post-reset cycle is a fresh fetch.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable from assertion through the mem_ready cycle.
  - The transfer completes on the edge where mem_req=1 and mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - Each extra cycle of mem_ready=0 adds one cycle of latency.
- Latency with zero-wait memory (mem_ready tied 1):
  - BRANCH and JAL: 3 cycles.
  - LUI: 3 cycles.
  - R-type, OP-IMM and STORE: 4 cycles.
  - LOAD: 5 cycles.
- instruccion may change only on the ir_write edge. Decode outputs are valid from DECODE onward.

## Test plan
- Reset mid-fetch: assert rst with mem_req=1 and mem_ready=0 -> next cycle mem_req=0 and instret=0; after rst drops, FETCH mem_req=1 with mem_addr_sel=0.
- ALU sequence, zero-wait memory: 0x00500093 (addi) then 0x002081B3 (add).
  - addi is 4 cycles; in EXEC alu_b_sel=01; WB has reg_write=1, wb_sel=00.
  - instret reads 2 after 8 cycles.
- LOAD 0x0000A103 with 3 wait cycles in MEM -> mem_req held 4 cycles with mem_addr_sel=1 and mem_we=0; WB wb_sel=01; total 8 cycles.
- STORE 0x0020A023 -> MEM has mem_we=1; no reg_write in any cycle; retires in 4 cycles.
- Branches:
  - BEQ 0x00208463 with zero=1 -> EXEC pc_write=1, pc_src=1.
  - Same with zero=0 -> pc_write=0.
  - BNE (funct3=001) with zero=0 -> taken.
  - Each is 3 cycles, instret +1.
- Illegal 0x0000007F -> HALT after DECODE: illegal=1 and all enables 0 for 20 cycles; instret unchanged; rst -> FETCH.

Source files
------------

// File: rtl/control_multiciclo.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/exec/mem/wb over a shared
// datapath, runs the memory request/ready handshake and counts retired instructions.
module control_multiciclo (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruccion,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        target_write,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t     state, state_nxt;
    logic       retire;
    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instruccion[6:0];
    assign funct3 = instruccion[14:12];

    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        target_write = 1'b0;
        alu_a_sel    = 2'b00;
        alu_b_sel    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        illegal      = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_a_sel = 2'b01;
                alu_b_sel = 2'b10;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                // Precompute PC+imm into the target register for branches/JAL.
                alu_a_sel    = 2'b10;
                alu_b_sel    = 2'b01;
                target_write = 1'b1;
                case (opcode)
                    OP_LUI:                                 state_nxt = WB;
                    OP_RTYPE, OP_OPIMM, OP_LOAD, OP_STORE,
                    OP_JAL:                                 state_nxt = EXEC;
                    OP_BRANCH: state_nxt = (funct3 == 3'b000 || funct3 == 3'b001) ? EXEC : HALT;
                    default:                                state_nxt = HALT;
                endcase
            end
            EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_op    = 2'b10;
                        state_nxt = WB;
                    end
                    OP_OPIMM: begin
                        alu_b_sel = 2'b01;
                        alu_op    = 2'b10;
                        state_nxt = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel = 2'b01;
                        state_nxt = MEM;
                    end
                    OP_BRANCH: begin
                        alu_op = 2'b01;
                        if ((funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero)) begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                    default: state_nxt = HALT;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end
            end
            WB: begin
                reg_write = 1'b1;
                if (opcode == OP_LOAD)     wb_sel = 2'b01;
                else if (opcode == OP_LUI) wb_sel = 2'b11;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            HALT: illegal = 1'b1;
            default: state_nxt = HALT;
        endcase
        // Reset silences every output, including an in-flight memory request.
        if (rst) begin
            retire       = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 1'b0;
            target_write = 1'b0;
            alu_a_sel    = 2'b00;
            alu_b_sel    = 2'b00;
            alu_op       = 2'b00;
            reg_write    = 1'b0;
            wb_sel       = 2'b00;
            illegal      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            instret <= 32'd0;
        end else begin
            state <= state_nxt;
            if (retire) instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo: per-instruction vectors with a
// scoreboard of expected behaviour, plus reset and halt sequences.
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        rst, zero, mem_ready;
    logic [31:0] instruccion;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, target_write;
    logic [1:0]  alu_a_sel, alu_b_sel, alu_op, wb_sel;
    logic        reg_write, illegal;
    logic [31:0] instret;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_instret = 32'd0;

    always #5 clk = ~clk;

    control_multiciclo dut (
        .clk(clk), .rst(rst), .instruccion(instruccion), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .target_write(target_write),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .instret(instret)
    );

    typedef struct {
        logic [31:0] instr;
        logic        z;
        int          fw;      // fetch wait cycles
        int          mw;      // memory wait cycles
        int          cyc;     // cycles until retire (or until halt)
        int          fetchc;  // cycles with fetch request asserted
        int          memc;    // cycles with data request asserted
        logic        we;
        logic        rw;
        logic [1:0]  wb;
        logic [1:0]  bsel;    // alu_b_sel while alu_op=10, 11 if never
        logic        taken;
        logic        ill;
    } vec_t;

    vec_t vecs[11];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        vec_t e, o;
        int   fw, mw;
        logic done;
        fw = v.fw; mw = v.mw; done = 1'b0;
        sb.push_back(v);
        o = v;
        o.cyc = 0; o.fetchc = 0; o.memc = 0; o.we = 0; o.rw = 0; o.wb = 2'b00;
        o.bsel = 2'b11; o.taken = 0; o.ill = 0;
        zero = v.z;
        while (!done && o.cyc < 60) begin
            @(negedge clk);
            if (illegal) begin
                o.ill = 1'b1;
                done  = 1'b1;
            end else begin
                // Ready is also raised when no request is pending; it must be ignored.
                if (mem_req && !mem_addr_sel)     mem_ready = (fw == 0);
                else if (mem_req && mem_addr_sel) mem_ready = (mw == 0);
                else                              mem_ready = 1'b1;
                #1;
                if (mem_req && !mem_addr_sel) begin o.fetchc++; if (fw > 0) fw--; end
                if (mem_req && mem_addr_sel)  begin o.memc++; if (mem_we) o.we = 1'b1; if (mw > 0) mw--; end
                if (reg_write) begin o.rw = 1'b1; o.wb = wb_sel; end
                if (alu_op == 2'b10) o.bsel = alu_b_sel;
                if (pc_write && pc_src) o.taken = 1'b1;
                o.cyc++;
                @(posedge clk);
                #1;
                if (o.cyc == 1 || o.fetchc > 0 && o.cyc == o.fetchc) instruccion = v.instr;
                if (instret == model_instret + 32'd1) done = 1'b1;
            end
        end
        e = sb.pop_front();
        chk("done", {31'd0, done}, 32'd1);
        chk("cycles", o.cyc, e.cyc);
        chk("fetch_req_cycles", o.fetchc, e.fetchc);
        chk("mem_req_cycles", o.memc, e.memc);
        chk("mem_we", {31'd0, o.we}, {31'd0, e.we});
        chk("reg_write", {31'd0, o.rw}, {31'd0, e.rw});
        chk("wb_sel", {30'd0, o.wb}, {30'd0, e.wb});
        chk("alu_b_sel_funct", {30'd0, o.bsel}, {30'd0, e.bsel});
        chk("taken", {31'd0, o.taken}, {31'd0, e.taken});
        chk("illegal", {31'd0, o.ill}, {31'd0, e.ill});
        if (!e.ill) model_instret = model_instret + 32'd1;
        chk("instret", instret, model_instret);
    endtask

    initial begin
        //         instr          z  fw mw cyc fc mc we rw wb     bsel   tk ill
        vecs[0]  = '{32'h00500093, 0, 0, 0, 4, 1, 0, 0, 1, 2'b00, 2'b01, 0, 0}; // addi
        vecs[1]  = '{32'h002081B3, 0, 0, 0, 4, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0}; // add
        vecs[2]  = '{32'h0000A103, 0, 0, 3, 8, 1, 4, 0, 1, 2'b01, 2'b11, 0, 0}; // lw, 3 waits
        vecs[3]  = '{32'h0020A023, 0, 0, 0, 4, 1, 1, 1, 0, 2'b00, 2'b11, 0, 0}; // sw
        vecs[4]  = '{32'h00208463, 1, 0, 0, 3, 1, 0, 0, 0, 2'b00, 2'b11, 1, 0}; // beq taken
        vecs[5]  = '{32'h00208463, 0, 0, 0, 3, 1, 0, 0, 0, 2'b00, 2'b11, 0, 0}; // beq not taken
        vecs[6]  = '{32'h00209463, 0, 0, 0, 3, 1, 0, 0, 0, 2'b00, 2'b11, 1, 0}; // bne taken
        vecs[7]  = '{32'h00209463, 1, 0, 0, 3, 1, 0, 0, 0, 2'b00, 2'b11, 0, 0}; // bne not taken
        vecs[8]  = '{32'h123450B7, 0, 0, 0, 3, 1, 0, 0, 1, 2'b11, 2'b11, 0, 0}; // lui
        vecs[9]  = '{32'h008000EF, 0, 0, 0, 3, 1, 0, 0, 1, 2'b10, 2'b11, 1, 0}; // jal
        vecs[10] = '{32'h00500093, 0, 2, 0, 6, 3, 0, 0, 1, 2'b00, 2'b01, 0, 0}; // addi, slow fetch

        rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; instruccion = 32'h00000013;
        @(posedge clk); #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("fetch_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_alu", {26'd0, alu_a_sel, alu_b_sel, alu_op}, {26'd0, 2'b01, 2'b10, 2'b00});

        for (int i = 0; i < 11; i++) run(vecs[i]);

        // Reset while a fetch is stalled waiting for memory.
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("midfetch_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; #1;
        chk("rst_forces_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("midfetch_instret", instret, 32'd0);
        model_instret = 32'd0;
        @(negedge clk); #1;
        chk("rst_held_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0; #1;
        chk("postrst_fetch", {30'd0, mem_req, mem_addr_sel}, {30'd0, 2'b10});

        // Two back-to-back ALU ops after reset: instret reaches 2.
        run(vecs[0]);
        run(vecs[1]);
        chk("alu_seq_instret", instret, 32'd2);

        // Unsupported opcode halts after decode and stays halted.
        run('{32'h0000007F, 0, 0, 0, 2, 1, 0, 0, 0, 2'b00, 2'b11, 0, 1});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            chk("halt_state", {25'd0, illegal, mem_req, mem_we, ir_write, pc_write, target_write, reg_write},
                {25'd0, 7'b1000000});
            chk("halt_instret", instret, model_instret);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; #1;
        chk("halt_exit", {29'd0, illegal, mem_req, mem_addr_sel}, {29'd0, 3'b010});
        chk("halt_exit_instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
